imem_line_buffer: RTL

//  Instruction-memory responder on the fetch stage's im_addr/im_busy/im_dout port.

---
 rtl/imem_line_buffer.sv | 112 +++++++++++
 1 files changed

// File: rtl/imem_line_buffer.sv
// Single-line instruction buffer between fetch and backing memory.
// Hits answer combinationally; misses refill the whole line word 0 first.
module imem_line_buffer #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [ADDR_W-1:0] im_addr_i,
    input  logic              flush_i,
    output logic              im_busy_o,
    output logic [31:0]       im_dout_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [31:0]       mem_rdata_i
);

    localparam int CNT_W = $clog2(LINE_WORDS);
    localparam int OFF   = CNT_W + 2;
    localparam int TAG_W = ADDR_W - OFF;

    typedef enum logic {
        IDLE,
        FILL
    } state_e;

    state_e             state_q, state_d;
    logic               valid_q, valid_d;
    logic               flush_pend_q, flush_pend_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [31:0]        line_q [LINE_WORDS];
    logic [31:0]        line_d [LINE_WORDS];

    logic [TAG_W-1:0]   addr_tag;
    logic [CNT_W-1:0]   addr_word;
    logic               hit;
    logic               last_word;
    logic               unused_addr_lsb;

    assign addr_tag        = im_addr_i[ADDR_W-1:OFF];
    assign addr_word       = im_addr_i[OFF-1:2];
    assign unused_addr_lsb = ^im_addr_i[1:0];
    assign last_word       = (cnt_q == CNT_W'(LINE_WORDS - 1));

    assign hit       = valid_q && (addr_tag == tag_q) && (state_q == IDLE);
    assign im_busy_o = ~hit;
    assign im_dout_o = hit ? line_q[addr_word] : 32'h0;

    assign mem_req_o  = (state_q == FILL);
    assign mem_addr_o = {tag_q, cnt_q, 2'b00};

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        cnt_d        = cnt_q;
        tag_d        = tag_q;
        line_d       = line_q;
        unique case (state_q)
            IDLE: begin
                // A flush suppresses the miss fill for this cycle
                if (flush_i) begin
                    valid_d = 1'b0;
                end else if (!hit) begin
                    tag_d   = addr_tag;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                if (flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    line_d[cnt_q] = mem_rdata_i;
                    if (last_word) begin
                        valid_d      = ~(flush_pend_q | flush_i);
                        flush_pend_d = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            tag_q        <= '0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= 32'h0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            cnt_q        <= cnt_d;
            tag_q        <= tag_d;
            line_q       <= line_d;
        end
    end

endmodule
